// File: rtl/alu_sequencer_pkg.sv
// Instruction-set types shared by the ALU sequencer and the ALU.
// Operation encodings, flag bundle, sequencer states and decode helpers.
package InstructionSetPkg;

  localparam int DataWidth      = 16;
  localparam int ImmediateWidth = 8;
  localparam int RegIdxWidth    = 5;
  localparam int CountWidth     = 4;

  typedef enum logic [3:0] {
    MOVE = 4'd0,
    ADD  = 4'd1,
    SUB  = 4'd2,
    AND  = 4'd3,
    OR   = 4'd4,
    XOR  = 4'd5,
    NOR  = 4'd6,
    SHL  = 4'd7,
    SHR  = 4'd8,
    MUL  = 4'd9,
    MUH  = 4'd10,
    DIV  = 4'd11,
    MOD  = 4'd12
  } eOperation;

  typedef struct packed {
    logic Zero;
    logic Negative;
    logic Carry;
    logic Overflow;
  } sFlags;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    HOLD = 2'd2
  } eSeqState;

  function automatic logic IsMultiCycle(
    input eOperation op
  );
    return op inside {MUL, MUH, DIV, MOD};
  endfunction

  function automatic logic IsDefinedOp(
    input eOperation op
  );
    return 4'(op) <= 4'(MOD);
  endfunction

  function automatic logic IsDivByZero(
    input eOperation            op,
    input logic [DataWidth-1:0] src
  );
    return (op inside {DIV, MOD})
      && (src == '0);
  endfunction

endpackage

// File: rtl/alu_sequencer.sv
// Sequences one request at a time through an external ALU and
// holds the result for write-back; owns the architectural flags.
module alu_sequencer
  import InstructionSetPkg::*;
#(
  parameter int unsigned MultiCycleLatency = 4
) (
  input  logic                      Clock,
  input  logic                      nReset,
  input  logic                      ReqValid,
  output logic                      ReqReady,
  input  eOperation                 ReqOp,
  input  logic [ImmediateWidth-1:0] ReqImm,
  input  logic [DataWidth-1:0]      ReqSrc,
  input  logic [DataWidth-1:0]      ReqDest,
  input  logic [RegIdxWidth-1:0]    ReqDestIdx,
  output eOperation                 AluOperation,
  output sFlags                     AluInFlags,
  output logic [ImmediateWidth-1:0] AluImm,
  output logic [DataWidth-1:0]      AluSrc,
  output logic [DataWidth-1:0]      AluDest,
  input  logic [DataWidth-1:0]      AluOutDest,
  input  sFlags                     AluOutFlags,
  output logic                      RspValid,
  input  logic                      RspReady,
  output logic [DataWidth-1:0]      RspData,
  output logic [RegIdxWidth-1:0]    RspDestIdx,
  output sFlags                     Flags,
  output logic                      Busy,
  output logic                      DivErr,
  input  logic                      Flush
);

  localparam logic [CountWidth-1:0] Latency =
    CountWidth'(MultiCycleLatency);

  eSeqState                  state;
  logic [CountWidth-1:0]     count;
  eOperation                 lat_op;
  logic [ImmediateWidth-1:0] lat_imm;
  logic [DataWidth-1:0]      lat_src;
  logic [DataWidth-1:0]      lat_dest;
  logic [RegIdxWidth-1:0]    lat_idx;

  logic accept;
  logic req_div_zero;
  logic lat_div_zero;
  logic lat_defined;

  assign accept       = ReqReady && ReqValid;
  assign req_div_zero = IsDivByZero(ReqOp, ReqSrc);
  assign lat_div_zero = IsDivByZero(lat_op, lat_src);
  assign lat_defined  = IsDefinedOp(lat_op);

  assign AluOperation = lat_op;
  assign AluImm       = lat_imm;
  assign AluSrc       = lat_src;
  assign AluDest      = lat_dest;
  assign AluInFlags   = Flags;

  always_ff @(posedge Clock or negedge nReset) begin
    if (!nReset) begin
      state      <= IDLE;
      count      <= '0;
      lat_op     <= MOVE;
      lat_imm    <= '0;
      lat_src    <= '0;
      lat_dest   <= '0;
      lat_idx    <= '0;
      Flags      <= '0;
      RspData    <= '0;
      RspDestIdx <= '0;
      RspValid   <= 1'b0;
      ReqReady   <= 1'b0;
      Busy       <= 1'b0;
      DivErr     <= 1'b0;
    end else if (Flush) begin
      state    <= IDLE;
      count    <= '0;
      RspValid <= 1'b0;
      ReqReady <= 1'b1;
      Busy     <= 1'b0;
      DivErr   <= 1'b0;
    end else begin
      DivErr <= 1'b0;
      unique case (state)
        IDLE: begin
          if (accept) begin
            lat_op   <= ReqOp;
            lat_imm  <= ReqImm;
            lat_src  <= ReqSrc;
            lat_dest <= ReqDest;
            lat_idx  <= ReqDestIdx;
            // a zero divisor skips the long countdown
            count    <= (IsMultiCycle(ReqOp) && !req_div_zero)
                        ? Latency : CountWidth'(1);
            DivErr   <= req_div_zero;
            state    <= EXEC;
            ReqReady <= 1'b0;
            Busy     <= 1'b1;
          end else begin
            ReqReady <= 1'b1;
          end
        end
        EXEC: begin
          if (count == CountWidth'(1)) begin
            unique case (1'b1)
              lat_div_zero: begin
                RspData <= '0;
              end
              !lat_defined: begin
                RspData <= '0;
                Flags   <= AluOutFlags;
              end
              default: begin
                RspData <= AluOutDest;
                Flags   <= AluOutFlags;
              end
            endcase
            RspDestIdx <= lat_idx;
            RspValid   <= 1'b1;
            state      <= HOLD;
          end else begin
            count <= count - CountWidth'(1);
          end
        end
        HOLD: begin
          if (RspReady) begin
            RspValid <= 1'b0;
            ReqReady <= 1'b1;
            Busy     <= 1'b0;
            state    <= IDLE;
          end
        end
        default: begin
          state    <= IDLE;
          RspValid <= 1'b0;
          ReqReady <= 1'b0;
          Busy     <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_sequencer.sv
// Randomized and directed bench for alu_sequencer with a behavioural
// ALU attached and a transaction-level reference model.
module tb_alu_sequencer;
  import InstructionSetPkg::*;

  localparam int LAT = 4;

  logic        Clock = 1'b0;
  logic        nReset = 1'b0;
  logic        ReqValid = 1'b0;
  logic        ReqReady;
  eOperation   ReqOp = MOVE;
  logic [7:0]  ReqImm = '0;
  logic [15:0] ReqSrc = '0;
  logic [15:0] ReqDest = '0;
  logic [4:0]  ReqDestIdx = '0;
  eOperation   AluOperation;
  sFlags       AluInFlags;
  logic [7:0]  AluImm;
  logic [15:0] AluSrc;
  logic [15:0] AluDest;
  logic [15:0] AluOutDest;
  sFlags       AluOutFlags;
  logic        RspValid;
  logic        RspReady = 1'b0;
  logic [15:0] RspData;
  logic [4:0]  RspDestIdx;
  sFlags       Flags;
  logic        Busy;
  logic        DivErr;
  logic        Flush = 1'b0;

  int    tests = 0;
  int    fails = 0;
  sFlags mflags = '0;

  alu_sequencer #(.MultiCycleLatency(LAT)) dut (
    .Clock(Clock), .nReset(nReset),
    .ReqValid(ReqValid), .ReqReady(ReqReady),
    .ReqOp(ReqOp), .ReqImm(ReqImm),
    .ReqSrc(ReqSrc), .ReqDest(ReqDest),
    .ReqDestIdx(ReqDestIdx),
    .AluOperation(AluOperation),
    .AluInFlags(AluInFlags), .AluImm(AluImm),
    .AluSrc(AluSrc), .AluDest(AluDest),
    .AluOutDest(AluOutDest),
    .AluOutFlags(AluOutFlags),
    .RspValid(RspValid), .RspReady(RspReady),
    .RspData(RspData), .RspDestIdx(RspDestIdx),
    .Flags(Flags), .Busy(Busy), .DivErr(DivErr),
    .Flush(Flush)
  );

  always #5 Clock = ~Clock;

  // behavioural ALU: {flags, result}
  function automatic logic [19:0] alu_fn(
    input logic [3:0] op, input logic [15:0] s,
    input logic [15:0] d, input logic [7:0] imm,
    input sFlags fi);
    logic [16:0] w;
    logic [31:0] p;
    logic [15:0] r;
    sFlags fo;
    fo = fi;
    p = 32'(d) * 32'(s);
    case (op)
      4'd0:  r = s;
      4'd1:  begin w = 17'(d) + 17'(s); r = w[15:0]; fo.Carry = w[16]; end
      4'd2:  begin w = 17'(d) - 17'(s); r = w[15:0]; fo.Carry = w[16]; end
      4'd3:  r = d & s;
      4'd4:  r = d | s;
      4'd5:  r = d ^ s;
      4'd6:  r = ~(d | s);
      4'd7:  r = d << imm[3:0];
      4'd8:  r = d >> imm[3:0];
      4'd9:  r = p[15:0];
      4'd10: r = p[31:16];
      4'd11: r = (s == 0) ? 16'hDEAD : d / s;
      4'd12: r = (s == 0) ? 16'hDEAD : d % s;
      default: r = 16'hBEEF;
    endcase
    fo.Zero = (r == 16'd0);
    fo.Negative = r[15];
    return {fo, r};
  endfunction

  always_comb begin
    {AluOutFlags, AluOutDest} = alu_fn(4'(AluOperation),
      AluSrc, AluDest, AluImm, AluInFlags);
  end

  function automatic void ref_model(
    input logic [3:0] op, input logic [15:0] src,
    input logic [15:0] dest, input logic [7:0] imm,
    input sFlags fin, output logic [15:0] d,
    output sFlags f, output int lat, output bit derr);
    logic [19:0] r;
    r = alu_fn(op, src, dest, imm, fin);
    derr = (op == 4'd11 || op == 4'd12) && src == 16'd0;
    lat = (op >= 4'd9 && op <= 4'd12 && !derr) ? LAT : 1;
    if (derr) begin d = 16'd0; f = fin; end
    else if (op > 4'd12) begin d = 16'd0; f = sFlags'(r[19:16]); end
    else begin d = r[15:0]; f = sFlags'(r[19:16]); end
  endfunction

  task automatic step();
    @(posedge Clock);
    #1;
  endtask

  task automatic wait_ready();
    int w;
    w = 0;
    while (ReqReady !== 1'b1 && w < 20) begin step(); w++; end
    tests++;
    if (ReqReady !== 1'b1) begin
      fails++;
      $display("FAIL wait_ready: ReqReady=%b required 1", ReqReady);
    end
  endtask

  task automatic drive_req(input logic [3:0] op, input logic [15:0] src,
    input logic [15:0] dest, input logic [7:0] imm, input logic [4:0] idx);
    ReqValid = 1'b1;
    ReqOp = eOperation'(op);
    ReqSrc = src;
    ReqDest = dest;
    ReqImm = imm;
    ReqDestIdx = idx;
  endtask

  task automatic scramble_req();
    ReqOp = eOperation'(4'($urandom_range(0, 15)));
    ReqSrc = 16'($urandom);
    ReqDest = 16'($urandom);
    ReqImm = 8'($urandom);
    ReqDestIdx = 5'($urandom);
  endtask

  task automatic do_op(input logic [3:0] op, input logic [15:0] src,
    input logic [15:0] dest, input logic [7:0] imm,
    input logic [4:0] idx, input int delay);
    logic [15:0] ed;
    sFlags ef;
    int lat, n, nerr;
    bit derr;
    ref_model(op, src, dest, imm, mflags, ed, ef, lat, derr);
    wait_ready();
    drive_req(op, src, dest, imm, idx);
    step();
    ReqValid = 1'b0;
    scramble_req();
    n = 1;
    nerr = 0;
    while (RspValid !== 1'b1 && n < 40) begin
      tests++;
      if ({AluOperation, AluSrc, AluDest, AluImm, AluInFlags, Busy, ReqReady}
          !== {op, src, dest, imm, mflags, 1'b1, 1'b0}) begin
        fails++;
        $display("FAIL exec_drive op=%0d: alu=%h/%h/%h/%h fl=%b busy=%b rdy=%b required %h/%h/%h/%h fl=%b busy=1 rdy=0",
          op, AluOperation, AluSrc, AluDest, AluImm, AluInFlags, Busy, ReqReady,
          op, src, dest, imm, mflags);
      end
      if (DivErr === 1'b1) nerr++;
      step();
      n++;
    end
    tests++;
    if (n !== lat + 1) begin
      fails++;
      $display("FAIL latency op=%0d: rsp after %0d cycles required %0d", op, n, lat + 1);
    end
    tests++;
    if (nerr !== int'(derr)) begin
      fails++;
      $display("FAIL div_err op=%0d: pulse cycles=%0d required %0d", op, nerr, derr);
    end
    tests++;
    if ({RspValid, RspData, RspDestIdx, Flags, DivErr} !== {1'b1, ed, idx, ef, 1'b0}) begin
      fails++;
      $display("FAIL result op=%0d: v=%b data=%h idx=%0d fl=%b derr=%b required v=1 data=%h idx=%0d fl=%b derr=0",
        op, RspValid, RspData, RspDestIdx, Flags, DivErr, ed, idx, ef);
    end
    mflags = ef;
    for (int i = 0; i < delay; i++) begin
      ReqValid = 1'b1;
      scramble_req();
      step();
      tests++;
      if ({RspValid, RspData, RspDestIdx, Flags, ReqReady, Busy}
          !== {1'b1, ed, idx, ef, 1'b0, 1'b1}) begin
        fails++;
        $display("FAIL hold_stable op=%0d: v=%b data=%h idx=%0d fl=%b rdy=%b busy=%b required v=1 data=%h idx=%0d fl=%b rdy=0 busy=1",
          op, RspValid, RspData, RspDestIdx, Flags, ReqReady, Busy, ed, idx, ef);
      end
    end
    ReqValid = 1'b0;
    RspReady = 1'b1;
    step();
    RspReady = 1'b0;
    tests++;
    if ({RspValid, ReqReady, Busy} !== 3'b010) begin
      fails++;
      $display("FAIL release op=%0d: v/rdy/busy=%b%b%b required 010",
        op, RspValid, ReqReady, Busy);
    end
  endtask

  task automatic test_reset();
    nReset = 1'b0;
    step();
    step();
    tests++;
    if ({ReqReady, RspValid, Busy, DivErr, Flags, RspData, RspDestIdx}
        !== '0 || AluOperation !== MOVE || AluSrc !== 16'd0) begin
      fails++;
      $display("FAIL reset_state: rdy=%b v=%b busy=%b derr=%b fl=%b data=%h idx=%0d aluop=%0d required all 0",
        ReqReady, RspValid, Busy, DivErr, Flags, RspData, RspDestIdx, AluOperation);
    end
    nReset = 1'b1;
    #1;
    tests++;
    if (ReqReady !== 1'b0) begin
      fails++;
      $display("FAIL reset_release: ReqReady=%b required 0 before edge", ReqReady);
    end
    step();
    tests++;
    if (ReqReady !== 1'b1 || Busy !== 1'b0) begin
      fails++;
      $display("FAIL reset_first_edge: rdy=%b busy=%b required 1 0", ReqReady, Busy);
    end
    mflags = '0;
  endtask

  task automatic test_directed();
    do_op(4'(MOVE), 16'h1234, 16'h0000, 8'h00, 5'd3, 0);
    do_op(4'(MUL), 16'h0005, 16'h0003, 8'h00, 5'd4, 0);
    do_op(4'(NOR), 16'h0000, 16'h0000, 8'h00, 5'd7, 10);
    do_op(4'(DIV), 16'h0000, 16'h0010, 8'h00, 5'd8, 1);
    do_op(4'(MOD), 16'h0000, 16'h0077, 8'h00, 5'd9, 0);
    do_op(4'(SUB), 16'h0001, 16'h0000, 8'h00, 5'd1, 0);
    do_op(4'd14, 16'h0102, 16'h0304, 8'h05, 5'd2, 2);
    do_op(4'(DIV), 16'h0007, 16'h0064, 8'h00, 5'd5, 0);
  endtask

  task automatic test_flush();
    wait_ready();
    drive_req(4'(MUL), 16'h0009, 16'h0009, 8'h00, 5'd6);
    step();
    ReqValid = 1'b0;
    step();
    Flush = 1'b1;
    step();
    Flush = 1'b0;
    tests++;
    if ({ReqReady, Busy, RspValid} !== 3'b100 || Flags !== mflags) begin
      fails++;
      $display("FAIL flush_exec: rdy/busy/v=%b%b%b fl=%b required 100 fl=%b",
        ReqReady, Busy, RspValid, Flags, mflags);
    end
    for (int i = 0; i < 6; i++) begin
      step();
      tests++;
      if (RspValid !== 1'b0 || Flags !== mflags) begin
        fails++;
        $display("FAIL flush_quiet: v=%b fl=%b required 0 fl=%b", RspValid, Flags, mflags);
      end
    end
    drive_req(4'(MOVE), 16'h5555, 16'h0, 8'h0, 5'd1);
    Flush = 1'b1;
    step();
    ReqValid = 1'b0;
    Flush = 1'b0;
    tests++;
    if ({ReqReady, Busy} !== 2'b10) begin
      fails++;
      $display("FAIL flush_idle: rdy/busy=%b%b required 10", ReqReady, Busy);
    end
    step();
    tests++;
    if (RspValid !== 1'b0 || Busy !== 1'b0) begin
      fails++;
      $display("FAIL flush_idle_rsp: v=%b busy=%b required 0 0", RspValid, Busy);
    end
  endtask

  task automatic test_flush_hold();
    logic [15:0] ed;
    sFlags ef;
    int lat, w;
    bit derr;
    ref_model(4'(ADD), 16'hFFFF, 16'h0001, 8'h0, mflags, ed, ef, lat, derr);
    wait_ready();
    drive_req(4'(ADD), 16'hFFFF, 16'h0001, 8'h0, 5'd2);
    step();
    ReqValid = 1'b0;
    w = 0;
    while (RspValid !== 1'b1 && w < 20) begin step(); w++; end
    mflags = ef;
    Flush = 1'b1;
    step();
    Flush = 1'b0;
    tests++;
    if ({RspValid, ReqReady, Busy} !== 3'b010 || Flags !== ef) begin
      fails++;
      $display("FAIL flush_hold: v/rdy/busy=%b%b%b fl=%b required 010 fl=%b",
        RspValid, ReqReady, Busy, Flags, ef);
    end
  endtask

  task automatic test_random();
    logic [3:0] op;
    logic [15:0] src;
    for (int i = 0; i < 40; i++) begin
      op = 4'($urandom_range(0, 15));
      src = ($urandom_range(0, 3) == 0) ? 16'd0 : 16'($urandom);
      do_op(op, src, 16'($urandom), 8'($urandom),
        5'($urandom), int'($urandom_range(0, 3)));
    end
  endtask

  task automatic test_reset_hold();
    int w;
    wait_ready();
    drive_req(4'(NOR), 16'h0000, 16'h0000, 8'h0, 5'd11);
    step();
    ReqValid = 1'b0;
    w = 0;
    while (RspValid !== 1'b1 && w < 20) begin step(); w++; end
    nReset = 1'b0;
    #1;
    tests++;
    if ({RspValid, ReqReady, Busy, DivErr, Flags, RspData} !== '0) begin
      fails++;
      $display("FAIL reset_hold: v=%b rdy=%b busy=%b derr=%b fl=%b data=%h required all 0",
        RspValid, ReqReady, Busy, DivErr, Flags, RspData);
    end
    step();
    nReset = 1'b1;
    step();
    mflags = '0;
    tests++;
    if ({ReqReady, Busy, RspValid} !== 3'b100) begin
      fails++;
      $display("FAIL reset_hold_recover: rdy/busy/v=%b%b%b required 100",
        ReqReady, Busy, RspValid);
    end
    do_op(4'(ADD), 16'h0002, 16'h0003, 8'h0, 5'd12, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: bench did not finish in time");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_directed();
    test_flush();
    test_flush_hold();
    test_random();
    test_reset_hold();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/alu_sequencer.md
ALU_SEQUENCER -- requirements
Module: alu_sequencer

Interface
REQ-001 SHALL have parameter MultiCycleLatency, default 4, meaning EXEC cycles for MUL/MUH/DIV/MOD (legal range 2..15).
REQ-002 SHALL have port Clock  in  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port nReset  in  1  asynchronous, active-low reset.
REQ-004 SHALL have ports ReqValid in 1, ReqReady out 1: request handshake; transfer when both are high on a Clock edge.
REQ-005 SHALL have ports ReqOp in eOperation, ReqImm in ImmediateWidth, ReqSrc in DataWidth, ReqDest in DataWidth, ReqDestIdx in RegIdxWidth: request payload.
REQ-006 SHALL have ports AluOperation out eOperation, AluInFlags out sFlags, AluImm out ImmediateWidth, AluSrc out DataWidth, AluDest out DataWidth: drive the ALU.
REQ-007 SHALL have ports AluOutDest in DataWidth, AluOutFlags in sFlags: ALU results.
REQ-008 SHALL have ports RspValid out 1, RspReady in 1, RspData out DataWidth, RspDestIdx out RegIdxWidth: write-back handshake.
REQ-009 SHALL have ports Flags out sFlags (architectural flags register), Busy out 1, DivErr out 1, Flush in 1.

Function
REQ-010 SHALL implement FSM states IDLE, EXEC, HOLD.
REQ-011 IDLE: ReqReady=1; on ReqValid, latch ReqOp/Imm/Src/Dest/DestIdx, load cycle counter, go to EXEC.
REQ-012 EXEC length SHALL be 1 cycle for all ops except MUL/MUH/DIV/MOD, which take MultiCycleLatency cycles.
REQ-013 Alu* outputs SHALL be driven from the latched request only, constant for all of EXEC; AluInFlags SHALL equal Flags.
REQ-014 On last EXEC cycle: capture AluOutDest into RspData, AluOutFlags into Flags, DestIdx into RspDestIdx; next state HOLD.
REQ-015 HOLD: RspValid=1, RspData/RspDestIdx stable; on RspReady go to IDLE (no same-cycle new accept; minimum 3 cycles per op).
REQ-016 ReqReady SHALL be 1 only in IDLE; Busy SHALL be 1 in EXEC and HOLD.
REQ-017 DIV/MOD with latched Src==0: skip EXEC countdown (1 cycle), RspData=0, Flags unchanged, DivErr high for exactly that one cycle, then HOLD.
REQ-018 Operation not in eOperation's defined set: treated as single-cycle; RspData=0, Flags take AluOutFlags.
REQ-019 Flush (synchronous, highest priority after reset): any state -> IDLE next cycle; no Flags update, no RspValid, pending result discarded.
REQ-020 Flush and ReqValid in IDLE same cycle: request SHALL NOT be accepted.
REQ-021 Counter SHALL be 4 bits, decrement in EXEC, saturate-free: exits EXEC on value 1.
REQ-022 RspValid without RspReady SHALL hold indefinitely with no output change.

Reset
REQ-023 nReset low SHALL asynchronously force state IDLE, counter 0, Flags all 0, RspData 0, RspDestIdx 0, latched request 0 (AluOperation = MOVE encoding of zero value).
REQ-024 Outputs during reset: ReqReady 0, RspValid 0, Busy 0, DivErr 0; ReqReady rises first Clock edge after nReset deasserts.
REQ-025 Reset mid-EXEC or mid-HOLD SHALL discard operation with no Flags update.

Structure
REQ-026 eOperation, sFlags, DataWidth, ImmediateWidth, RegIdxWidth SHALL come from InstructionSetPkg; add eSeqState and function IsMultiCycle(eOperation) there.
REQ-027 SHALL contain no arithmetic; single sub-module instance ArithmeticLogicUnit is instantiated by the parent, not here.
REQ-028 No sub-modules inside alu_sequencer.

Verification (DataWidth=16, MultiCycleLatency=4, ALU model connected)
REQ-029 MOVE Src=0x1234, RspReady=1 -> RspValid on cycle 2 after accept, RspData=0x1234, ReqReady high cycle 3.
REQ-030 MUL Dest=0x0003 Src=0x0005 -> RspValid 5 cycles after accept, RspData=0x000F, Flags.Zero=0.
REQ-031 DIV Dest=0x0010 Src=0x0000 -> DivErr one-cycle pulse, RspData=0x0000, Flags equal prior value.
REQ-032 NOR Src=Dest=0, RspReady low 10 cycles -> RspValid held, RspData=0xFFFF stable, ReqValid ignored.
REQ-033 MUL accepted, Flush on 2nd EXEC cycle -> IDLE next cycle, no RspValid, Flags unchanged.
REQ-034 nReset low during HOLD -> RspValid 0 immediately (asynchronous), Flags 0.
